sg_mux8_core: RTL and testbench

// Eight-tone multiplexed signal generator for a DAC datapath. Emits N_DDS parallel 16-bit samples per clock.

---
 rtl/sg_mux8_core.sv | 235 +++++++++++++++++++++++
 tb/tb_sg_mux8_core.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sg_mux8_core.sv
// Eight-tone multiplexed DDS generator, N_DDS lanes per clock, descriptor-queued windows.
// Define SG_MUX_SAT_EN to saturate lane sums; otherwise they wrap to 16 bits.
module sg_mux8_core #(
    parameter int N_DDS      = 16,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                 aclk,
    input  logic                 areset,
    input  logic                 reg_we,
    input  logic [4:0]           reg_addr,
    input  logic [31:0]          reg_wdata,
    input  logic [39:0]          s_axis_tdata,
    input  logic                 s_axis_tvalid,
    output logic                 s_axis_tready,
    output logic [N_DDS*16-1:0]  m_axis_tdata,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready
);

    localparam int  AW = $clog2(FIFO_DEPTH);
    localparam real PI = 3.14159265358979323846;

    typedef enum logic {S_IDLE, S_RUN} state_t;

    function automatic logic signed [15:0] sin_val(input int idx);
        real r;
        int  v;
        int  base;
        base = idx % 512;
        r = 32767.0 * $sin(2.0 * PI * real'(base) / 1024.0);
        v = $rtoi(r + 0.5);
        return (idx >= 512) ? 16'(-v) : 16'(v);
    endfunction

    function automatic logic [9:0] ph_idx(input logic [31:0] a, input logic [31:0] inc,
                                          input logic [31:0] off, input logic [31:0] lane);
        logic [31:0] p;
        p = a + inc * lane + off;
        return p[31:22];
    endfunction

    function automatic logic signed [18:0] term_of(input logic signed [15:0] s,
                                                   input logic [15:0] g);
        logic signed [32:0] p;
        p = s * $signed({1'b0, g});
        return {p[32], p[32:15]};
    endfunction

    function automatic logic [15:0] sat16(input logic signed [18:0] s);
`ifdef SG_MUX_SAT_EN
        if (s > 19'sd32767)       return 16'h7fff;
        else if (s < -19'sd32768) return 16'h8000;
        else                      return s[15:0];
`else
        return s[15:0];
`endif
    endfunction

    logic signed [15:0] lut [1024];
    for (genvar g = 0; g < 1024; g++) begin : g_lut
        assign lut[g] = sin_val(g);
    end

    logic [31:0] pinc_s [8];
    logic [31:0] poff_s [8];
    logic [15:0] gain_s [8];
    logic [31:0] pinc_a [8];
    logic [31:0] poff_a [8];
    logic [15:0] gain_a [8];
    logic [31:0] acc    [8];
    logic        commit;

    assign commit = reg_we && reg_addr == 5'd24 && reg_wdata[0];

    always_ff @(posedge aclk) begin
        if (areset) begin
            for (int k = 0; k < 8; k++) begin
                pinc_s[k] <= '0;
                poff_s[k] <= '0;
                gain_s[k] <= '0;
            end
        end else if (reg_we) begin
            unique case (1'b1)
                reg_addr[4:3] == 2'd0: pinc_s[reg_addr[2:0]] <= reg_wdata;
                reg_addr[4:3] == 2'd1: poff_s[reg_addr[2:0]] <= reg_wdata;
                reg_addr[4:3] == 2'd2: gain_s[reg_addr[2:0]] <= reg_wdata[15:0];
                default: ;
            endcase
        end
    end

    // Accumulators restart with every commit so equal-PINC tones stay coherent.
    always_ff @(posedge aclk) begin
        for (int k = 0; k < 8; k++) begin
            if (areset) begin
                pinc_a[k] <= '0;
                poff_a[k] <= '0;
                gain_a[k] <= '0;
                acc[k]    <= '0;
            end else if (commit) begin
                pinc_a[k] <= pinc_s[k];
                poff_a[k] <= poff_s[k];
                gain_a[k] <= gain_s[k];
                acc[k]    <= '0;
            end else begin
                acc[k] <= acc[k] + pinc_a[k] * 32'(N_DDS);
            end
        end
    end

    logic [39:0]   mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic [39:0]   head;

    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = wr_ptr == rd_ptr;
    assign s_axis_tready = !full;
    // Zero-length descriptors are accepted but never stored, so they cost no cycle.
    assign push = s_axis_tvalid && !full && (s_axis_tdata[31:0] != 32'd0);
    assign head = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge aclk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= s_axis_tdata;
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    state_t      state;
    state_t      state_n;
    logic [31:0] cnt;
    logic [7:0]  mask;
    logic [7:0]  run_mask;

    always_comb begin
        state_n = state;
        pop     = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_n = S_RUN;
                end
            end
            S_RUN: begin
                if (cnt == 32'd1) begin
                    if (!empty) pop = 1'b1;
                    else        state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state <= S_IDLE;
            cnt   <= '0;
            mask  <= '0;
        end else begin
            state <= state_n;
            if (pop) begin
                mask <= head[39:32];
                cnt  <= head[31:0];
            end else if (state == S_RUN) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    assign run_mask = (state == S_RUN) ? mask : 8'h00;

    logic [9:0]          idx1 [N_DDS][8];
    logic signed [15:0]  sv2  [N_DDS][8];
    logic [7:0]          mask1;
    logic [7:0]          mask2;
    logic signed [18:0]  lane_sum [N_DDS];
    logic [N_DDS*16-1:0] tdata_n;

    always_ff @(posedge aclk) begin
        for (int l = 0; l < N_DDS; l++) begin
            for (int k = 0; k < 8; k++) begin
                idx1[l][k] <= ph_idx(acc[k], pinc_a[k], poff_a[k], 32'(l));
                sv2[l][k]  <= lut[idx1[l][k]];
            end
        end
    end

    always_comb begin
        for (int l = 0; l < N_DDS; l++) begin
            lane_sum[l] = '0;
            for (int k = 0; k < 8; k++) begin
                if (mask2[k]) lane_sum[l] = lane_sum[l] + term_of(sv2[l][k], gain_a[k]);
            end
        end
    end

    always_comb begin
        tdata_n = '0;
        for (int l = 0; l < N_DDS; l++) begin
            tdata_n[16*l +: 16] = sat16(lane_sum[l]);
        end
    end

    // The window mask rides the pipeline with the data, so idle cycles sum nothing.
    always_ff @(posedge aclk) begin
        if (areset) begin
            mask1         <= '0;
            mask2         <= '0;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
        end else begin
            mask1         <= run_mask;
            mask2         <= mask1;
            m_axis_tdata  <= tdata_n;
            m_axis_tvalid <= 1'b1;
        end
    end

    logic unused_ok;
    assign unused_ok = m_axis_tready;

endmodule

// File: tb/tb_sg_mux8_core.sv
// Directed bench for sg_mux8_core: reset, DC and tone windows, chaining, queue, clipping.
// Expected clipping values follow whether SG_MUX_SAT_EN is defined.
module tb_sg_mux8_core;

    localparam int N = 16;

    logic          aclk = 1'b0;
    logic          areset;
    logic          reg_we;
    logic [4:0]    reg_addr;
    logic [31:0]   reg_wdata;
    logic [39:0]   s_tdata;
    logic          s_tvalid;
    logic          s_tready;
    logic [N*16-1:0] m_tdata;
    logic          m_tvalid;
    logic          m_tready;

    int n_cmp = 0;
    int n_bad = 0;

    int nz_cnt, first_nz, last_nz, max_abs, lane_dev, odd_cnt, big_cnt;
    int vals [$];

    sg_mux8_core #(.N_DDS(N), .FIFO_DEPTH(16)) dut (
        .aclk          (aclk),
        .areset        (areset),
        .reg_we        (reg_we),
        .reg_addr      (reg_addr),
        .reg_wdata     (reg_wdata),
        .s_axis_tdata  (s_tdata),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready)
    );

    always #5 aclk = ~aclk;

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic chk(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int lane(input int i);
        return int'($signed(m_tdata[16*i +: 16]));
    endfunction

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        reg_we    = 1'b1;
        reg_addr  = a;
        reg_wdata = d;
        tick();
        reg_we    = 1'b0;
    endtask

    task automatic push(input logic [7:0] m, input logic [31:0] n);
        s_tvalid = 1'b1;
        s_tdata  = {m, n};
        tick();
        s_tvalid = 1'b0;
    endtask

    task automatic do_reset();
        areset = 1'b1;
        repeat (3) tick();
        areset = 1'b0;
        tick();
    endtask

    task automatic collect(input int n);
        int v;
        int a;
        nz_cnt = 0; first_nz = -1; last_nz = -1; max_abs = 0;
        lane_dev = 0; odd_cnt = 0; big_cnt = 0;
        vals.delete();
        for (int c = 0; c < n; c++) begin
            tick();
            if (m_tdata != '0) begin
                nz_cnt++;
                if (first_nz < 0) first_nz = c;
                last_nz = c;
                vals.push_back(lane(0));
            end
            for (int i = 0; i < N; i++) begin
                v = lane(i);
                a = (v < 0) ? -v : v;
                if (a > max_abs) max_abs = a;
                if (v != lane(0)) lane_dev++;
                if (v % 2 != 0) odd_cnt++;
                if (a > 1) big_cnt++;
            end
        end
    endtask

    initial begin
        int accepted;
        areset = 1'b1; reg_we = 1'b0; reg_addr = '0; reg_wdata = '0;
        s_tdata = '0; s_tvalid = 1'b0; m_tready = 1'b1;

        repeat (5) tick();
        chk("rst_tdata", m_tdata == '0, 1);
        chk("rst_tvalid", m_tvalid, 0);
        areset = 1'b0;
        tick();
        chk("rel_tready", s_tready, 1);
        chk("rel_tvalid", m_tvalid, 1);
        chk("rel_tdata", m_tdata == '0, 1);

        // DC tone at sine peak: 32767*30000>>>15 = 29999
        wr(5'd8, 32'h4000_0000);
        wr(5'd16, 32'd30000);
        wr(5'd24, 32'd1);
        push(8'h01, 32'd5);
        collect(12);
        chk("dc_latency", first_nz, 3);
        chk("dc_count", nz_cnt, 5);
        chk("dc_first", vals[0], 29999);
        chk("dc_last", vals[4], 29999);
        chk("dc_lanes_eq", lane_dev, 0);

        // Shadow write without commit leaves the active gain alone
        wr(5'd16, 32'd1000);
        wr(5'd30, 32'hFFFF_FFFF);
        push(8'h01, 32'd3);
        collect(10);
        chk("shadow_val", vals[0], 29999);
        chk("shadow_count", nz_cnt, 3);
        wr(5'd24, 32'd1);
        push(8'h01, 32'd2);
        collect(10);
        chk("commit_val", vals[0], 999);

        // Trough: -32767*30000>>>15 floors to -30000
        do_reset();
        wr(5'd8, 32'hC000_0000);
        wr(5'd16, 32'd30000);
        wr(5'd24, 32'd1);
        push(8'h01, 32'd4);
        collect(10);
        chk("neg_val", vals[0], -30000);
        chk("neg_count", nz_cnt, 4);

        // 1 MHz tone, 100 cycles
        do_reset();
        wr(5'd0, 32'd2684356);
        wr(5'd16, 32'd30000);
        wr(5'd24, 32'd1);
        push(8'h01, 32'd100);
        collect(110);
        chk("tone_count", nz_cnt, 100);
        chk("tone_contig", last_nz - first_nz + 1, 100);
        chk("tone_peak", (max_abs >= 29900 && max_abs <= 30000), 1);

        // Two coherent half-gain tones sum to exactly twice one term
        do_reset();
        wr(5'd0, 32'd2684356);
        wr(5'd1, 32'd2684356);
        wr(5'd16, 32'd15000);
        wr(5'd17, 32'd15000);
        wr(5'd24, 32'd1);
        push(8'h03, 32'd2500);
        collect(2510);
        chk("coh_count", nz_cnt, 2500);
        chk("coh_odd", odd_cnt, 0);
        chk("coh_peak", (max_abs >= 29990 && max_abs <= 30000), 1);

        // Anti-phase tones cancel to 0 or -1
        do_reset();
        wr(5'd0, 32'd2684356);
        wr(5'd2, 32'd2684356);
        wr(5'd10, 32'h8000_0000);
        wr(5'd16, 32'd30000);
        wr(5'd18, 32'd30000);
        wr(5'd24, 32'd1);
        push(8'h05, 32'd2500);
        collect(2510);
        chk("cancel_big", big_cnt, 0);
        chk("cancel_count", nz_cnt, 2500);

        // Chained descriptors, zero-length one skipped without a gap
        do_reset();
        wr(5'd8, 32'h4000_0000);
        wr(5'd15, 32'h4000_0000);
        wr(5'd10, 32'h4000_0000);
        wr(5'd16, 32'd30000);
        wr(5'd23, 32'd1000);
        wr(5'd18, 32'd2000);
        wr(5'd24, 32'd1);
        push(8'h81, 32'd10);
        push(8'h03, 32'd0);
        push(8'h05, 32'd10);
        collect(30);
        chk("chain_count", nz_cnt, 20);
        chk("chain_contig", last_nz - first_nz + 1, 20);
        chk("chain_a0", vals[0], 30998);
        chk("chain_a9", vals[9], 30998);
        chk("chain_b0", vals[10], 31998);
        chk("chain_b9", vals[19], 31998);

        // Fill the queue behind a long waveform
        do_reset();
        wr(5'd8, 32'h4000_0000);
        wr(5'd16, 32'd30000);
        wr(5'd24, 32'd1);
        push(8'h01, 32'd1000);
        repeat (3) tick();
        accepted = 0;
        s_tvalid = 1'b1;
        s_tdata  = {8'h01, 32'd5};
        for (int c = 0; c < 20; c++) begin
            if (s_tready) accepted++;
            tick();
        end
        s_tvalid = 1'b0;
        chk("fifo_accepted", accepted, 16);
        chk("fifo_full_tready", s_tready, 0);

        // Reset mid-waveform aborts output and flushes the queue
        areset = 1'b1;
        tick();
        chk("abort_zero", m_tdata == '0, 1);
        areset = 1'b0;
        tick();
        chk("abort_tready", s_tready, 1);
        collect(20);
        chk("abort_flushed", nz_cnt, 0);

        // Clipping: 29999+29999 and -30000-30000
        do_reset();
        wr(5'd8, 32'h4000_0000);
        wr(5'd9, 32'h4000_0000);
        wr(5'd16, 32'd30000);
        wr(5'd17, 32'd30000);
        wr(5'd24, 32'd1);
        push(8'h03, 32'd3);
        collect(8);
`ifdef SG_MUX_SAT_EN
        chk("clip_pos", vals[0], 32767);
`else
        chk("clip_pos", vals[0], -5538);
`endif
        wr(5'd8, 32'hC000_0000);
        wr(5'd9, 32'hC000_0000);
        wr(5'd24, 32'd1);
        push(8'h03, 32'd3);
        collect(8);
`ifdef SG_MUX_SAT_EN
        chk("clip_neg", vals[0], -32768);
`else
        chk("clip_neg", vals[0], 5536);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
